// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with registered sync, blanking and colour.
// Ports: Clk, Reset (sync, active-high); Red_In/Green_In/Blue_In colour for Xpos/Ypos;
//        Xpos/Ypos live counters; Hsync/Vsync active-low; Video_On; Frame_Start pulse;
//        Red/Green/Blue registered DAC colour.
// Build option: define VGA_PIXEL_TICK_EN to advance the raster every second Clk.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Red_In,
    input  logic [3:0]  Green_In,
    input  logic [3:0]  Blue_In,
    output logic [15:0] Xpos,
    output logic [15:0] Ypos,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Video_On,
    output logic        Frame_Start,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
    localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
    localparam logic [15:0] HS_FIRST = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0] HS_LAST  = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST = 16'(V_VISIBLE + V_FRONT);
    localparam logic [15:0] VS_LAST  = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [15:0] hcount;
    logic [15:0] vcount;
    logic        pix_tick;
    logic        h_last;
    logic        v_last;
    logic        visible;
    logic        hsync_n;
    logic        vsync_n;

`ifdef VGA_PIXEL_TICK_EN
    // Cleared by reset so the first advance lands on the second edge after release.
    always_ff @(posedge Clk) begin
        if (Reset)
            pix_tick <= 1'b0;
        else
            pix_tick <= ~pix_tick;
    end
`else
    assign pix_tick = 1'b1;
`endif

    always_comb begin
        h_last  = (hcount == H_LAST);
        v_last  = (vcount == V_LAST);
        visible = (hcount < H_VIS) && (vcount < V_VIS);
        hsync_n = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
        vsync_n = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + 16'd1;
            end else begin
                hcount <= hcount + 16'd1;
            end
        end
    end

    // Timing and colour describe the pixel just counted, so they trail Xpos/Ypos by one tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Hsync    <= 1'b1;
            Vsync    <= 1'b1;
            Video_On <= 1'b0;
            Red      <= '0;
            Green    <= '0;
            Blue     <= '0;
        end else if (pix_tick) begin
            Hsync    <= hsync_n;
            Vsync    <= vsync_n;
            Video_On <= visible;
            Red      <= visible ? Red_In   : 4'h0;
            Green    <= visible ? Green_In : 4'h0;
            Blue     <= visible ? Blue_In  : 4'h0;
        end
    end

    // Updated every Clk (not only on ticks) so the pulse is one Clk wide.
    always_ff @(posedge Clk) begin
        if (Reset)
            Frame_Start <= 1'b0;
        else
            Frame_Start <= pix_tick && h_last && v_last;
    end

    assign Xpos = hcount;
    assign Ypos = vcount;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have these parameters: H_VISIBLE, 640, active pixels per line.
REQ-002 H_FRONT, 16, horizontal front porch in pixels.
REQ-003 H_SYNC, 96, horizontal sync width in pixels.
REQ-004 H_BACK, 48, horizontal back porch in pixels.
REQ-005 V_VISIBLE, 480, active lines per frame.
REQ-006 V_FRONT, 10, vertical front porch in lines.
REQ-007 V_SYNC, 2, vertical sync width in lines.
REQ-008 V_BACK, 33, vertical back porch in lines.
REQ-009 The block SHALL have this port: Clk  in  1  single system clock; all logic on its rising edge.
REQ-010 Reset  in  1  synchronous, active-high reset.
REQ-011 Red_In / Green_In / Blue_In  in  4 each  pixel colour from the pixel controller for the current Xpos/Ypos.
REQ-012 Xpos  out  16  current horizontal count, 0..H_TOTAL-1.
REQ-013 Ypos  out  16  current vertical count, 0..V_TOTAL-1.
REQ-014 Hsync / Vsync  out  1 each  active-low sync outputs, registered.
REQ-015 Video_On  out  1  high while the registered RGB outputs are in the visible area.
REQ-016 Frame_Start  out  1  one-Clk pulse at each frame wrap.
REQ-017 Red / Green / Blue  out  4 each  registered colour to the DAC.

Function
REQ-018 H_TOTAL SHALL equal the sum of the four H parameters (800); V_TOTAL SHALL equal the sum of the four V parameters (525).
REQ-019 Counters SHALL advance only on cycles where the internal pixel tick is high.
REQ-020 On a tick, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-021 At (H_TOTAL-1, V_TOTAL-1), both counters SHALL wrap to 0 on the same tick.
REQ-022 Xpos and Ypos SHALL be driven directly from hcount and vcount, zero-extended to 16 bits, with no latency.
REQ-023 Visible SHALL be defined as hcount < H_VISIBLE and vcount < V_VISIBLE.
REQ-024 Hsync SHALL be low for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
REQ-025 Vsync SHALL be low for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
REQ-026 On each tick, Hsync, Vsync, Video_On and RGB SHALL register the values for the current counters, giving a latency of one tick relative to Xpos/Ypos.
REQ-027 Registered RGB SHALL equal the *_In inputs when visible and SHALL be forced to 0 otherwise.
REQ-028 Between ticks, all registered outputs SHALL hold their values.
REQ-029 Frame_Start SHALL be high for exactly one Clk, in the cycle after a tick in which the counters wrapped from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-030 Frame_Start SHALL be low at all other times, including the cycles after reset.

Reset
REQ-031 Reset high at a Clk edge SHALL set hcount=0, vcount=0, pixel tick=0, Hsync=1, Vsync=1, Video_On=0, Frame_Start=0 and Red/Green/Blue=0.
REQ-032 Reset SHALL take priority over any tick in the same cycle.
REQ-033 Reset asserted mid-line or mid-frame SHALL abort immediately with no partial-pulse completion.
REQ-034 After Reset deasserts, counting SHALL restart from (0,0).

Configuration
REQ-035 With macro VGA_PIXEL_TICK_EN defined, the pixel tick SHALL be a register that toggles every Clk, so counters advance every second Clk (50 MHz Clk gives a 25 MHz pixel rate). The first advance SHALL occur on the second Clk edge after Reset deasserts.
REQ-036 Without VGA_PIXEL_TICK_EN, the pixel tick SHALL be constant 1 and counters SHALL advance every Clk.

Verification
REQ-037 Scenario: Reset for 3 cycles, then release -> Xpos=0, Ypos=0, Hsync=Vsync=1, RGB=0, Frame_Start=0; Xpos=1 after 1 tick.
REQ-038 Scenario: run to Xpos=799 -> next tick Xpos=0, Ypos increments by 1; Hsync low for exactly 96 ticks, starting one tick after Xpos=656.
REQ-039 Scenario: run a full frame -> Vsync low for exactly 2 lines, starting after Ypos=490; Frame_Start pulses once per 420000 ticks, of width one Clk.
REQ-040 Scenario: drive Red_In/Green_In/Blue_In=4'hA constantly -> Video_On=1 with RGB=4'hA for 640 ticks per line on lines 0..479; RGB=0 at Xpos 640..799 and Ypos 480..524.
REQ-041 Scenario: assert Reset at Xpos=700, Ypos=300 (Hsync low) -> next cycle Hsync=1, counters=(0,0), no Frame_Start pulse.
REQ-042 Scenario: build with VGA_PIXEL_TICK_EN -> Xpos changes every 2 Clk and a frame lasts 840000 Clk; build without it -> Xpos changes every Clk.
